// File: rtl/mem_port_ctrl_pkg.sv
// Shared types and defaults for the RAM initiator port controller.
// Holds the request/response FSM state encoding and default bus widths.
package mem_port_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/mem_port_ctrl_fetch_tracker.sv
// Instruction fetch tracker: tags each fetched byte with its pc and invalidates it
// when a store to the same address lands in the cycle the byte is read.
module fetch_tracker
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              st_accept,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] mem_data_out_B,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] fetch_data_pc
);

    logic              hazard;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    // The RAM's port B samples the old byte when a write hits the same address.
    assign hazard = st_accept && (st_addr == fetch_pc);

    always_comb begin
        valid_d = !hazard;
        pc_d    = fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

    assign mem_pc        = fetch_pc;
    assign fetch_valid   = valid_q;
    assign fetch_data_pc = pc_q;
    assign fetch_data    = mem_data_out_B;

endmodule

// File: rtl/mem_port_ctrl.sv
// Initiator for the 256x8 synchronous RAM: turns core load/store requests into RAM
// strobes, absorbs the one-cycle read latency and returns load data with backpressure.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic [ADDR_W-1:0] fetch_data_pc,
    output logic [ADDR_W-1:0] mem_addr_read_A,
    output logic              mem_read_en_A,
    output logic [ADDR_W-1:0] mem_addr_write,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_pc,
    input  logic [DATA_W-1:0] mem_data_out_A,
    input  logic [DATA_W-1:0] mem_data_out_B
);

    state_e state_q, state_d;
    logic   accept;
    logic   ld_accept;
    logic   st_accept;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        ld_accept = 1'b0;
        st_accept = 1'b0;
        rsp_valid = 1'b0;

        // A held response blocks new requests so data_out_A is never overwritten.
        if (!sync_rst) begin
            req_ready = (state_q == IDLE) || rsp_ready;
        end
        accept    = req_valid && req_ready;
        ld_accept = accept && !req_we;
        st_accept = accept && req_we;

        case (state_q)
            IDLE: begin
                if (ld_accept) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ld_accept ? RESP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_data        = mem_data_out_A;
    assign mem_read_en_A   = ld_accept;
    assign mem_addr_read_A = req_addr;
    assign mem_write_en    = st_accept;
    assign mem_addr_write  = req_addr;
    assign mem_data        = req_wdata;

    fetch_tracker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fetch_tracker (
        .clk            (clk),
        .sync_rst       (sync_rst),
        .fetch_pc       (fetch_pc),
        .st_accept      (st_accept),
        .st_addr        (req_addr),
        .mem_data_out_B (mem_data_out_B),
        .mem_pc         (mem_pc),
        .fetch_valid    (fetch_valid),
        .fetch_data     (fetch_data),
        .fetch_data_pc  (fetch_data_pc)
    );

endmodule

// File: doc/mem_port_ctrl.md
Name: mem_port_ctrl

Overview:
- Initiator side of the 256x8 synchronous RAM: the only block that drives the RAM's read-A, write and pc ports.
- Converts core load/store requests (valid/ready) into RAM port strobes and absorbs the RAM's one-cycle registered read latency.
- Returns load data through a response handshake with backpressure.
- Tracks instruction fetch: tags each fetched byte with its pc and invalidates it on a same-address store hazard.

Parameters:
ADDR_W, 8, address width (RAM depth = 2**ADDR_W)
DATA_W, 8, data width

Ports:
clk  in  1  clock, all state on rising edge
sync_rst  in  1  synchronous, active-high reset
req_valid  in  1  core request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  load response valid
rsp_ready  in  1  core accepts response
rsp_data  out  DATA_W  load data
fetch_pc  in  ADDR_W  pc to fetch this cycle
fetch_valid  out  1  fetch_data valid for fetch_data_pc
fetch_data  out  DATA_W  instruction byte
fetch_data_pc  out  ADDR_W  pc that produced fetch_data
mem_addr_read_A  out  ADDR_W  to RAM addr_read_A
mem_read_en_A  out  1  to RAM read_en_A
mem_addr_write  out  ADDR_W  to RAM addr_write
mem_data  out  DATA_W  to RAM data
mem_write_en  out  1  to RAM write_en
mem_pc  out  ADDR_W  to RAM pc
mem_data_out_A  in  DATA_W  from RAM data_out_A
mem_data_out_B  in  DATA_W  from RAM data_out_B

Behaviour:
- Clocking and reset: one clock (clk); reset sync_rst is synchronous and active-high.
- Reset values:
  - state = IDLE, rsp_valid = 0, fetch_valid = 0, fetch_data_pc = 0.
  - While sync_rst=1: req_ready, mem_read_en_A and mem_write_en are forced 0.
- FSM states:
  - IDLE: no load outstanding.
  - RESP: load data is sitting on mem_data_out_A.
- Acceptance rule:
  - req_ready = !sync_rst & (IDLE | (RESP & rsp_ready)).
  - accept = req_valid & req_ready.
- Store accept: mem_write_en=1, mem_addr_write=req_addr, mem_data=req_wdata, all combinational in the accept cycle. No response. Next state is IDLE, or stays RESP if an existing response is still held.
- Load accept: mem_read_en_A=1, mem_addr_read_A=req_addr combinational in the accept cycle; next state is RESP.
- RESP state:
  - rsp_valid=1, rsp_data=mem_data_out_A. The RAM holds data_out_A because read_en_A stays low.
  - rsp_ready=1 with no new load: go to IDLE.
  - rsp_ready=1 with a new load accepted the same cycle: stay in RESP (back-to-back, one load per cycle).
  - rsp_ready=0: hold. rsp_data must stay stable and no new request is accepted.
- Load latency: rsp_valid rises one cycle after accept.
- Ordering:
  - A load after a store to the same address, in the next or any later cycle, returns the new data.
  - Only one request is accepted per cycle, so a same-cycle store+load cannot occur.
- Fetch path:
  - mem_pc = fetch_pc (combinational).
  - Each cycle: fetch_data_pc <= fetch_pc; fetch_valid <= !sync_rst & !hazard.
  - hazard = store accepted this cycle & req_addr == fetch_pc. The RAM read returns the old byte in that case, so the byte must be invalidated.
  - fetch_data = mem_data_out_B (combinational).
  - Re-presenting the same pc in the following cycle yields fetch_valid=1 with the new byte.
- Reset mid-operation: a pending RESP is dropped (rsp_valid 0 next cycle). Core must reissue.
- Address wrap: 8'hFF is a normal address; no wrap logic.
- When idle, mem_addr_read_A/mem_addr_write/mem_data may carry don't-care values; only the enables matter.

Decomposition:
- Package mem_port_pkg: state enum (IDLE, RESP), ADDR_W/DATA_W defaults.
- One sub-module fetch_tracker: pc register, hazard compare, fetch_valid register.
- The request/response FSM stays in mem_port_ctrl.

Test Plan:
- Reset, then idle → rsp_valid=0, fetch_valid=0 during reset; fetch_valid=1 one cycle after reset released with fetch_pc held at 0.
- Store 0x5A to 0x10, then load 0x10 next cycle → rsp_valid one cycle after load accept, rsp_data=0x5A.
- Load 0x20 with rsp_ready=0 for 3 cycles → rsp_valid and rsp_data stable for 3 cycles, req_ready=0, no mem_read_en_A pulses.
- Loads to 0x01, 0x02, 0x03 back-to-back with rsp_ready=1 → one response per cycle, in order, with correct data.
- Store 0x77 to 0x40 while fetch_pc=0x40 → next cycle fetch_valid=0, fetch_data_pc=0x40; pc held → following cycle fetch_valid=1, fetch_data=0x77.
- Assert sync_rst while in RESP → rsp_valid=0 next cycle, state IDLE, no RAM write enable during reset.
